de_responder: RTL
=================

# de_responder

Memory-side responder for the drawing-engine pixel port (de_req/de_ack). It accepts byte-masked 32-bit writes and 32-bit reads from a drawing engine such as the dithering cell, posts writes into a small FIFO so the engine is released quickly, and drains them to a framebuffer memory port with a request/grant handshake. Reads are ordered behind all posted writes. It sits between the drawing engines and the framebuffer memory controller.

## Interface
- WBUF_DEPTH, 4: posted-write FIFO entries (power of two, 2..16)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- de_req  in  1  initiator request; fields stable while high
- de_ack  out  1  one-cycle acknowledge; on reads, de_r_data valid in the same cycle
- de_addr  in  18  word address
- de_nbyte  in  4  active-low byte lanes; bit i = 0 writes byte i (bits [8i+7:8i])
- de_rnw  in  1  1 = read, 0 = write
- de_w_data  in  32  write data
- de_r_data  out  32  read data, registered
- mem_req  out  1  memory command valid
- mem_gnt  in  1  command accepted when mem_req && mem_gnt at a rising edge
- mem_addr  out  18  memory word address
- mem_rnw  out  1  1 = read command
- mem_be  out  4  active-high byte enables (= ~de_nbyte)
- mem_w_data  out  32  memory write data
- mem_r_data  in  32  memory read data
- mem_r_valid  in  1  one-cycle strobe carrying mem_r_data for the single outstanding read
- busy  out  1  high when FIFO non-empty or a read is in progress

## Operation
- Reset values: de_ack=0, de_r_data=0, mem_req=0, mem_addr=0, mem_rnw=0, mem_be=0, mem_w_data=0, busy=0; FIFO empty, state IDLE.
- Acceptance rule: de_req is sampled only at an edge where de_ack is currently 0 and state is IDLE. At the edge where de_ack is 1, the request is ignored, because the initiator advances on that same edge.
- Write, FIFO not full: capture {addr, ~nbyte, w_data} at edge E. de_ack=1 for the cycle after E.
- Write, FIFO full: no acceptance. de_req stays pending until an entry drains.
- Write with de_nbyte=4'b1111: acknowledged as a normal write, never enqueued (no-op).
- Read: state IDLE→RD_DRAIN, capturing the address.
  - RD_DRAIN: wait until the FIFO is empty and no write command is pending on mem.
  - →RD_ISSUE: mem_req=1, mem_rnw=1; hold until mem_gnt.
  - →RD_WAIT: wait for mem_r_valid; capture mem_r_data into de_r_data.
  - →RD_ACK: de_ack=1 for one cycle.
  - →IDLE.
- Drain side: when the FIFO is non-empty and state is not RD_ISSUE/RD_WAIT, present the head on mem_* with mem_req=1, mem_rnw=0. Pop at the edge where mem_gnt=1. The next entry may be presented in the following cycle (one write per cycle at full grant).
- Ordering: writes reach memory in acceptance order. A read returns data reflecting every write acknowledged before it.
- Simultaneous enqueue and pop on a full FIFO: the pop frees the slot at that edge, but acceptance uses the full flag from before the edge, so the write waits one cycle.
- busy = FIFO non-empty OR state ≠ IDLE.
- rst mid-operation: FIFO flushed (posted writes lost), outstanding read abandoned; a later mem_r_valid is ignored in IDLE.
- mem_r_valid outside RD_WAIT is ignored.

## Timing
- Write latency, request to ack: 1 cycle (req sampled at E, ack high in E..E+1) when the FIFO has room.
- Write throughput at the de port: one every 2 cycles (acceptance is blocked in the ack cycle).
- Read latency: drain time + grant wait + memory latency + 1 cycle (capture into de_r_data) + ack cycle. Minimum with an empty FIFO, immediate grant and mem_r_valid one cycle after grant: ack high 4 cycles after the sampling edge.
- mem_* outputs are registered and held stable while mem_req=1 && mem_gnt=0.
- de_r_data holds its value until the next read completes.

## Test plan
- Single write: addr=0x00010, nbyte=4'b1110, data=0xA5A5A5A5, mem_gnt tied 1 → de_ack one cycle after the sampling edge; one mem command with addr 0x00010, be=4'b0001, data 0xA5A5A5A5.
- FIFO full: WBUF_DEPTH=4, mem_gnt=0, five back-to-back writes → 4 acks; the fifth is held with no ack. Raise mem_gnt → fifth acked; 5 writes reach memory in order.
- Read-after-write ordering: mem_gnt=0, write 0x12345678 to addr 3 with nbyte=0, then request a read of addr 3. Release mem_gnt, memory model echoes → the write is granted before the read command; de_r_data=0x12345678 at the read ack.
- No-op write: nbyte=4'b1111 → ack after 1 cycle, no mem_req, busy stays 0.
- Reset mid-read: rst pulsed in RD_WAIT, then mem_r_valid with 0xDEADBEEF → no de_ack, de_r_data=0, busy=0.
- Ack-cycle blocking: de_req held high with a constant write → acks occur every 2nd cycle, and the FIFO count rises by exactly 1 per ack.

Source files
------------

// File: rtl/de_responder.sv
// de_responder: memory-side responder for the drawing-engine pixel port.
// Writes from the engine are posted into a small FIFO and acknowledged at once.
// The FIFO drains to the framebuffer memory port over a request/grant handshake.
// A read waits until every posted write has been granted, then issues one
// memory read and acknowledges the engine with the returned word.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   de_req/de_ack   engine request, one-cycle acknowledge
//   de_addr         18-bit word address
//   de_nbyte        active-low byte lanes
//   de_rnw          1 = read, 0 = write
//   de_w_data       write data
//   de_r_data       registered read data, held until the next read completes
//   mem_req/mem_gnt memory command handshake (accepted when both high at an edge)
//   mem_addr, mem_rnw, mem_be, mem_w_data  registered memory command fields
//   mem_r_data/mem_r_valid  read return strobe for the single outstanding read
//   busy            FIFO non-empty or a read in progress
module de_responder #(
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [17:0] mem_addr,
  output logic        mem_rnw,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data,
  input  logic        mem_r_valid,
  output logic        busy
);

  localparam int unsigned PtrW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StRdDrain, StRdIssue, StRdWait, StRdAck} state_e;

  state_e state_q, state_d;

  logic [17:0] fifo_addr [WBUF_DEPTH];
  logic [3:0]  fifo_be   [WBUF_DEPTH];
  logic [31:0] fifo_data [WBUF_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        de_ack_q, de_ack_d;
  logic [31:0] de_r_data_q, de_r_data_d;
  logic [17:0] rd_addr_q, rd_addr_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_rnw_q, mem_rnw_d;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_w_data_q, mem_w_data_d;

  logic full, accept, push, pop, bypass, noop_wr;

  always_comb begin
    full    = (count_q == CntW'(WBUF_DEPTH));
    noop_wr = (de_nbyte == 4'hF);
    // Full flag is the pre-edge value: a pop on this edge does not admit a write.
    accept  = de_req && !de_ack_q && (state_q == StIdle) && (de_rnw || noop_wr || !full);
    push    = accept && !de_rnw && !noop_wr;
    pop     = mem_req_q && mem_gnt && !mem_rnw_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    // The entry being pushed becomes the head when everything older leaves now.
    bypass   = push && (count_q == CntW'(pop));
  end

  always_comb begin
    state_d     = state_q;
    de_ack_d    = 1'b0;
    de_r_data_d = de_r_data_q;
    rd_addr_d   = rd_addr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (de_rnw) begin
            state_d   = StRdDrain;
            rd_addr_d = de_addr;
          end else begin
            de_ack_d = 1'b1;
          end
        end
      end
      StRdDrain: begin
        if (count_q == '0 && !mem_req_q) state_d = StRdIssue;
      end
      StRdIssue: begin
        if (mem_gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (mem_r_valid) begin
          de_r_data_d = mem_r_data;
          state_d     = StRdAck;
        end
      end
      StRdAck: begin
        de_ack_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_d    = mem_req_q;
    mem_rnw_d    = mem_rnw_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_w_data_d = mem_w_data_q;
    if (state_q == StRdDrain && state_d == StRdIssue) begin
      mem_req_d    = 1'b1;
      mem_rnw_d    = 1'b1;
      mem_addr_d   = rd_addr_q;
      mem_be_d     = 4'hF;
      mem_w_data_d = '0;
    end else if (state_q == StRdIssue) begin
      if (mem_gnt) mem_req_d = 1'b0;
    end else if (!mem_req_q || mem_gnt) begin
      // Command slot is free after this edge: present the next head, if any.
      mem_rnw_d = 1'b0;
      if (count_d != '0) begin
        mem_req_d = 1'b1;
        if (bypass) begin
          mem_addr_d   = de_addr;
          mem_be_d     = ~de_nbyte;
          mem_w_data_d = de_w_data;
        end else begin
          mem_addr_d   = fifo_addr[rd_ptr_d];
          mem_be_d     = fifo_be[rd_ptr_d];
          mem_w_data_d = fifo_data[rd_ptr_d];
        end
      end else begin
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      de_ack_q     <= 1'b0;
      de_r_data_q  <= '0;
      rd_addr_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_rnw_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      de_ack_q     <= de_ack_d;
      de_r_data_q  <= de_r_data_d;
      rd_addr_q    <= rd_addr_d;
      mem_req_q    <= mem_req_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_w_data_q <= mem_w_data_d;
      if (push) begin
        fifo_addr[wr_ptr_q] <= de_addr;
        fifo_be[wr_ptr_q]   <= ~de_nbyte;
        fifo_data[wr_ptr_q] <= de_w_data;
      end
    end
  end

  assign de_ack     = de_ack_q;
  assign de_r_data  = de_r_data_q;
  assign mem_req    = mem_req_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_w_data = mem_w_data_q;
  assign busy       = (count_q != '0) || (state_q != StIdle);

endmodule
